// File: rtl/ddr3_line_packer_pkg.sv
// Shared constants and FSM encodings for the DDR3 line packer slice.
package ddr3_wr_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WR_FIFO_DEPTH  = 512;
    localparam int unsigned MIN_START_HOLD = 2;

    typedef logic [1:0] top_state_t;
    typedef logic [1:0] iss_state_t;

    localparam top_state_t TOP_WAIT_INIT  = 2'd0;
    localparam top_state_t TOP_WAIT_FRAME = 2'd1;
    localparam top_state_t TOP_RUN        = 2'd2;
    localparam top_state_t TOP_ERR        = 2'd3;

    localparam iss_state_t ISS_IDLE  = 2'd0;
    localparam iss_state_t ISS_ISSUE = 2'd1;
    localparam iss_state_t ISS_WAIT  = 2'd2;

endpackage

// File: rtl/ddr3_line_packer_if.sv
// Write-stage bus between the line packer (master) and the S2MM write stage (slave).
interface ddr3_line_packer_if;

    logic        pl_ddr_wr_start;
    logic [31:0] pl_ddr_wr_addr;
    logic [31:0] pl_ddr_wr_length;
    logic        pl_ddr_wr_en;
    logic [31:0] pl_ddr_wr_data;
    logic        wr_done;

    modport master (
        output pl_ddr_wr_start, pl_ddr_wr_addr, pl_ddr_wr_length,
        output pl_ddr_wr_en, pl_ddr_wr_data,
        input  wr_done
    );

    modport slave (
        input  pl_ddr_wr_start, pl_ddr_wr_addr, pl_ddr_wr_length,
        input  pl_ddr_wr_en, pl_ddr_wr_data,
        output wr_done
    );

endinterface

// File: rtl/ddr3_line_packer_sample_packer.sv
// Packs 16-bit samples into 32-bit words and flags the last word of each line.
// DDR3_LINE_PACKER_TEST_PATTERN_EN replaces packed data with a per-frame word counter.
module sample_packer_16to32 #(
    parameter int unsigned LINE_WORDS = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic        line_rdy
);

    localparam int unsigned CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);

    logic          phase;
    logic [15:0]   lo_half;
    logic [CW-1:0] word_cnt;
`ifdef DDR3_LINE_PACKER_TEST_PATTERN_EN
    logic [31:0]   pat_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= 1'b0;
            lo_half  <= '0;
            word_cnt <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            line_rdy <= 1'b0;
`ifdef DDR3_LINE_PACKER_TEST_PATTERN_EN
            pat_cnt  <= '0;
`endif
        end else begin
            wr_en    <= 1'b0;
            line_rdy <= 1'b0;
            if (clr) begin
                phase    <= 1'b0;
                word_cnt <= '0;
`ifdef DDR3_LINE_PACKER_TEST_PATTERN_EN
                pat_cnt  <= '0;
`endif
            end else if (!en) begin
                // leaving the packing window drops any half-built word
                phase <= 1'b0;
            end else if (sample_valid) begin
                if (!phase) begin
                    lo_half <= sample_data;
                    phase   <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    wr_en <= 1'b1;
`ifdef DDR3_LINE_PACKER_TEST_PATTERN_EN
                    wr_data <= pat_cnt;
                    pat_cnt <= pat_cnt + 32'd1;
`else
                    wr_data <= {sample_data, lo_half};
`endif
                    if (word_cnt == LAST_WORD) begin
                        word_cnt <= '0;
                        line_rdy <= 1'b1;
                    end else begin
                        word_cnt <= word_cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ddr3_line_packer.sv
// Line packer feeding the PL-to-DDR3 write stage: frame FSM, request-issue FSM, address stepping.
// Optional macro DDR3_LINE_PACKER_TEST_PATTERN_EN (handled in sample_packer_16to32).
module ddr3_line_packer
    import ddr3_wr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned LINE_WORDS = 80,
    parameter int unsigned NUM_LINES  = 4,
    parameter int unsigned START_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ddr3_init_complet,
    input  logic                      frame_start,
    input  logic                      sample_valid,
    input  logic [15:0]               sample_data,
    ddr3_line_packer_if.master        wr_if,
    output logic                      frame_done,
    output logic                      overflow,
    output logic                      busy
);

    localparam logic [31:0] LINE_BYTES = 32'(LINE_WORDS * BYTES_PER_WORD);
    localparam int unsigned IW = $clog2(NUM_LINES + 1);
    localparam int unsigned HW = $clog2(START_HOLD);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_LINES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);

    top_state_t    top_st;
    iss_state_t    iss_st;
    logic [IW-1:0] lines_packed;
    logic [IW-1:0] issue_idx;
    logic [HW-1:0] hold_cnt;
    logic          pending;
    logic          start_r;
    logic [31:0]   addr_r;

    logic          line_rdy;
    logic          pk_wr_en;
    logic [31:0]   pk_wr_data;
    logic          start_frame;
    logic          pack_en;
    logic          ovf_hit;
    logic [IW-1:0] idx_inc;

    function automatic logic [31:0] line_addr(input logic [IW-1:0] idx);
        return BASE_ADDR + (32'(idx) * LINE_BYTES);
    endfunction

    assign start_frame = frame_start && (top_st == TOP_WAIT_FRAME || top_st == TOP_ERR);
    assign pack_en     = (top_st == TOP_RUN) && (lines_packed != LAST_IDX);
    assign ovf_hit     = (top_st == TOP_RUN) && line_rdy && pending;
    assign idx_inc     = issue_idx + IW'(1);

    sample_packer_16to32 #(.LINE_WORDS(LINE_WORDS)) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr          (start_frame),
        .en           (pack_en),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .wr_en        (pk_wr_en),
        .wr_data      (pk_wr_data),
        .line_rdy     (line_rdy)
    );

    assign wr_if.pl_ddr_wr_start  = start_r;
    assign wr_if.pl_ddr_wr_addr   = addr_r;
    assign wr_if.pl_ddr_wr_length = LINE_BYTES;
    assign wr_if.pl_ddr_wr_en     = pk_wr_en;
    assign wr_if.pl_ddr_wr_data   = pk_wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_st       <= TOP_WAIT_INIT;
            iss_st       <= ISS_IDLE;
            lines_packed <= '0;
            issue_idx    <= '0;
            hold_cnt     <= '0;
            pending      <= 1'b0;
            start_r      <= 1'b0;
            addr_r       <= BASE_ADDR;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (top_st)
                TOP_WAIT_INIT: begin
                    if (ddr3_init_complet) top_st <= TOP_WAIT_FRAME;
                end
                TOP_WAIT_FRAME, TOP_ERR: begin
                    if (frame_start) begin
                        top_st       <= TOP_RUN;
                        iss_st       <= ISS_IDLE;
                        lines_packed <= '0;
                        issue_idx    <= '0;
                        pending      <= 1'b0;
                        start_r      <= 1'b0;
                        overflow     <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                TOP_RUN: begin
                    if (line_rdy) lines_packed <= lines_packed + IW'(1);
                    if (ovf_hit) begin
                        overflow <= 1'b1;
                        top_st   <= TOP_ERR;
                        iss_st   <= ISS_IDLE;
                        start_r  <= 1'b0;
                    end else begin
                        case (iss_st)
                            ISS_IDLE: begin
                                if (line_rdy || pending) begin
                                    iss_st   <= ISS_ISSUE;
                                    pending  <= 1'b0;
                                    start_r  <= 1'b1;
                                    hold_cnt <= '0;
                                    addr_r   <= line_addr(issue_idx);
                                end
                            end
                            ISS_ISSUE: begin
                                if (line_rdy) pending <= 1'b1;
                                if (hold_cnt == HOLD_LAST) begin
                                    start_r <= 1'b0;
                                    iss_st  <= ISS_WAIT;
                                end else begin
                                    hold_cnt <= hold_cnt + HW'(1);
                                end
                            end
                            ISS_WAIT: begin
                                if (line_rdy) pending <= 1'b1;
                                if (wr_if.wr_done) begin
                                    issue_idx <= idx_inc;
                                    // a pending line is picked up by IDLE on the following cycle
                                    iss_st    <= ISS_IDLE;
                                    if (idx_inc == LAST_IDX) begin
                                        frame_done <= 1'b1;
                                        busy       <= 1'b0;
                                        top_st     <= TOP_WAIT_FRAME;
                                    end
                                end
                            end
                            default: iss_st <= ISS_IDLE;
                        endcase
                    end
                end
                default: top_st <= TOP_WAIT_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_line_packer.sv
// Directed bench for ddr3_line_packer: scoreboarded words/requests plus directed timing checks.
module tb_ddr3_line_packer;

    localparam logic [31:0] BASE       = 32'h1000_0000;
    localparam int unsigned LWORDS     = 80;
    localparam int unsigned NLINES     = 4;
    localparam int unsigned HOLD       = 4;
    localparam logic [31:0] LBYTES     = 32'd320;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ddr3_init_complet = 1'b0;
    logic        frame_start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        frame_done;
    logic        overflow;
    logic        busy;

    ddr3_line_packer_if bus ();

    ddr3_line_packer #(
        .BASE_ADDR  (BASE),
        .LINE_WORDS (LWORDS),
        .NUM_LINES  (NLINES),
        .START_HOLD (HOLD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ddr3_init_complet (ddr3_init_complet),
        .frame_start       (frame_start),
        .sample_valid      (sample_valid),
        .sample_data       (sample_data),
        .wr_if             (bus),
        .frame_done        (frame_done),
        .overflow          (overflow),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    int          emit_cnt = 0;
    int          fd_cnt = 0;
    int          start_len = 0;
    logic        start_prev = 1'b0;
    logic        phase_tb = 1'b0;
    logic [15:0] lo_tb = '0;
    logic [31:0] pat_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard consumer: words and request pulses
    always @(negedge clk) begin
        if (rst) begin
            start_prev = 1'b0;
            start_len  = 0;
        end else begin
            if (bus.pl_ddr_wr_en) begin
                emit_cnt++;
                if (exp_q.size() == 0) check("unexpected_wr_en", 32'd1, 32'd0);
                else check("wr_data", bus.pl_ddr_wr_data, exp_q.pop_front());
            end
            if (bus.pl_ddr_wr_start) begin
                if (!start_prev) begin
                    start_len = 0;
                    if (addr_q.size() == 0) check("unexpected_start", 32'd1, 32'd0);
                    else check("start_addr", bus.pl_ddr_wr_addr, addr_q.pop_front());
                end
                start_len++;
            end else if (start_prev) begin
                check("start_hold", 32'(start_len), 32'(HOLD));
            end
            if (frame_done) fd_cnt++;
            start_prev = bus.pl_ddr_wr_start;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sample(input logic [15:0] d, input bit push_ok);
        sample_valid = 1'b1;
        sample_data  = d;
        if (phase_tb) begin
            if (push_ok) begin
`ifdef DDR3_LINE_PACKER_TEST_PATTERN_EN
                exp_q.push_back(pat_cnt);
                pat_cnt = pat_cnt + 32'd1;
`else
                exp_q.push_back({d, lo_tb});
`endif
            end
        end else begin
            lo_tb = d;
        end
        phase_tb = ~phase_tb;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_line(input logic [15:0] first);
        for (int i = 0; i < 2 * LWORDS; i++) send_sample(first + 16'(i), 1'b1);
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        phase_tb    = 1'b0;
        pat_cnt     = '0;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic pulse_wr_done();
        bus.wr_done = 1'b1;
        tick(1);
        bus.wr_done = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_start"},    32'(bus.pl_ddr_wr_start), 32'd0);
        check({pfx, "_addr"},     bus.pl_ddr_wr_addr, BASE);
        check({pfx, "_length"},   bus.pl_ddr_wr_length, LBYTES);
        check({pfx, "_wr_en"},    32'(bus.pl_ddr_wr_en), 32'd0);
        check({pfx, "_data"},     bus.pl_ddr_wr_data, 32'd0);
        check({pfx, "_fdone"},    32'(frame_done), 32'd0);
        check({pfx, "_overflow"}, 32'(overflow), 32'd0);
        check({pfx, "_busy"},     32'(busy), 32'd0);
    endtask

    initial begin
        int snap;
        bus.wr_done = 1'b0;

        // reset
        tick(3);
        check_reset_vals("rst");
        rst = 1'b0;
        tick(2);
        check("busy_before_frame", 32'(busy), 32'd0);

        // single line, first line of a full frame
        ddr3_init_complet = 1'b1;
        tick(2);
        pulse_frame_start();
        check("busy_after_start", 32'(busy), 32'd1);
`ifndef DDR3_LINE_PACKER_TEST_PATTERN_EN
        check("first_word_model", {16'h0002, 16'h0001}, 32'h0002_0001);
`endif
        addr_q.push_back(BASE);
        send_line(16'h0001);
        @(negedge clk);
        check("start_low_on_line_rdy", 32'(bus.pl_ddr_wr_start), 32'd0);
        @(negedge clk);
        check("start_rise_after_line_rdy", 32'(bus.pl_ddr_wr_start), 32'd1);
        tick(8);
        check("line1_words", 32'(emit_cnt), 32'd80);
        check("addr_held_line1", bus.pl_ddr_wr_addr, BASE);
        pulse_wr_done();

        for (int k = 1; k < 4; k++) begin
            addr_q.push_back(BASE + 32'(k) * LBYTES);
            send_line(16'(k) * 16'h1000 + 16'h0001);
            tick(8);
            pulse_wr_done();
        end
        tick(2);
        check("frame_done_count", 32'(fd_cnt), 32'd1);
        check("busy_after_frame", 32'(busy), 32'd0);
        check("last_addr", bus.pl_ddr_wr_addr, 32'h1000_03C0);
        snap = emit_cnt;
        for (int i = 0; i < 10; i++) send_sample(16'hBEEF, 1'b0);
        tick(3);
        check("extra_samples_no_wr_en", 32'(emit_cnt), 32'(snap));
        check("frame_words", 32'(emit_cnt), 32'd320);

        // pending: line 2 completes before line 1's wr_done
        pulse_frame_start();
        addr_q.push_back(BASE);
        addr_q.push_back(32'h1000_0140);
        send_line(16'h2001);
        send_line(16'h3001);
        tick(3);
        check("pending_no_overflow", 32'(overflow), 32'd0);
        pulse_wr_done();
        @(negedge clk);
        check("pending_start_low", 32'(bus.pl_ddr_wr_start), 32'd0);
        @(negedge clk);
        check("pending_start_high", 32'(bus.pl_ddr_wr_start), 32'd1);
        check("pending_addr", bus.pl_ddr_wr_addr, 32'h1000_0140);
        tick(8);
        pulse_wr_done();
        for (int k = 2; k < 4; k++) begin
            addr_q.push_back(BASE + 32'(k) * LBYTES);
            send_line(16'(k) * 16'h0100 + 16'h4001);
            tick(8);
            pulse_wr_done();
        end
        tick(2);
        check("frame_done_count2", 32'(fd_cnt), 32'd2);
        check("pending_overflow_end", 32'(overflow), 32'd0);

        // overflow: three lines, no wr_done
        pulse_frame_start();
        addr_q.push_back(BASE);
        send_line(16'h6001);
        send_line(16'h7001);
        send_line(16'h8001);
        tick(3);
        check("overflow_set", 32'(overflow), 32'd1);
        check("overflow_start_low", 32'(bus.pl_ddr_wr_start), 32'd0);
        snap = emit_cnt;
        for (int i = 0; i < 20; i++) send_sample(16'h0BAD, 1'b0);
        tick(2);
        check("overflow_no_wr_en", 32'(emit_cnt), 32'(snap));
        check("overflow_sticky", 32'(overflow), 32'd1);
        pulse_frame_start();
        check("overflow_cleared", 32'(overflow), 32'd0);
        check("overflow_busy", 32'(busy), 32'd1);
        addr_q.push_back(BASE);
        send_line(16'h9001);
        tick(8);
        check("recover_addr", bus.pl_ddr_wr_addr, BASE);
        pulse_wr_done();
        tick(2);

        // reset mid-line with a half-built word
        for (int i = 0; i < 51; i++) send_sample(16'hA000 + 16'(i), 1'b1);
        tick(1);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        check("midrst_queue_drained", 32'(exp_q.size()), 32'd0);
        phase_tb = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        pulse_frame_start();
        snap = emit_cnt;
        send_sample(16'h5001, 1'b1);
        send_sample(16'h5002, 1'b1);
        tick(3);
        check("post_rst_one_word", 32'(emit_cnt), 32'(snap + 1));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_addr_queue_empty", 32'(addr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
